// File: rtl/gabor_mac_if.sv
// Tap-sample input bus and output-memory write bus of the Gabor filter MAC.
interface gabor_mac_if;
    logic       tap_valid;
    logic [3:0] tap_idx;
    logic [7:0] pixel_in;
    logic [7:0] coeff_in;
    logic       win_last;
    logic [7:0] center_in;
    logic [7:0] out_data;
    logic [7:0] out_addr;
    logic       out_we;

    // Producer side: drives taps, observes output writes.
    modport master (
        output tap_valid, tap_idx, pixel_in, coeff_in, win_last, center_in,
        input  out_data, out_addr, out_we
    );

    // Filter side: consumes taps, issues output writes.
    modport slave (
        input  tap_valid, tap_idx, pixel_in, coeff_in, win_last, center_in,
        output out_data, out_addr, out_we
    );
endinterface

// File: rtl/gabor_mac.sv
// Gabor filter multiply-accumulate: 3x3 window of pixel*coeff taps summed,
// arithmetically shifted by SHIFT, clamped to 8 bits and written out.
// Pipeline: stage 1 multiply, stage 2 accumulate, snapshot, output write;
// out_we rises three edges after the edge that samples the last tap.
// Optional feature: define GABOR_ABS_EN to output min(|sum|,255) for
// negative sums instead of clamping them to zero.
module gabor_mac #(
    parameter int unsigned SHIFT      = 7,
    parameter int unsigned IMG_PIXELS = 256
) (
    input  logic        clk,
    input  logic        reset,
    gabor_mac_if.slave  bus,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned PROD_W = 17;
    localparam int unsigned ACC_W  = 21;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam logic [IDX_W-1:0]  LAST_TAP  = IDX_W'(8);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t state, state_next;

    // Stage 1 registers
    logic                     s1_valid;
    logic [IDX_W-1:0]         s1_idx;
    logic                     s1_last;
    logic [ADDR_W-1:0]        s1_center;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [PROD_W-1:0] prod_c;

    // Stage 2 registers
    logic signed [ACC_W-1:0]  acc;
    logic                     win_open;
    logic                     s2_last;
    logic [ADDR_W-1:0]        s2_center;
    logic                     accept_c;

    // Snapshot of a finished window, held while the next one accumulates
    logic [DATA_W-1:0]        fin_data;
    logic [ADDR_W-1:0]        fin_addr;
    logic signed [ACC_W-1:0]  shifted_c;
    logic [DATA_W-1:0]        clamp_c;

    // Output registers
    logic [DATA_W-1:0]        out_data_q;
    logic [ADDR_W-1:0]        out_addr_q;
    logic                     out_we_q;

    assign prod_c = PROD_W'($signed({1'b0, bus.pixel_in})) * PROD_W'($signed(bus.coeff_in));

    // A sample joins the accumulator if it opens a window or continues an open one.
    assign accept_c = s1_valid && ((s1_idx == '0) || win_open);

    // Stage 1: register product and tap metadata; out-of-range taps are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_last   <= 1'b0;
            s1_center <= '0;
            s1_prod   <= '0;
        end else begin
            s1_valid <= bus.tap_valid && (bus.tap_idx <= LAST_TAP);
            if (bus.tap_valid) begin
                s1_idx    <= bus.tap_idx;
                s1_last   <= bus.win_last;
                s1_center <= bus.center_in;
                s1_prod   <= prod_c;
            end
        end
    end

    // Stage 2: accumulate; tap 0 restarts the sum, abandoning any open window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            win_open  <= 1'b0;
            s2_last   <= 1'b0;
            s2_center <= '0;
        end else begin
            s2_last <= accept_c && s1_last;
            if (accept_c) begin
                acc       <= (s1_idx == '0) ? ACC_W'(s1_prod) : acc + ACC_W'(s1_prod);
                win_open  <= !s1_last;
                s2_center <= s1_center;
            end
        end
    end

`ifdef GABOR_ABS_EN
    logic signed [ACC_W-1:0] mag_c;
`endif

    // Scale and saturate the accumulated sum to an 8-bit pixel.
    always_comb begin
        shifted_c = acc >>> SHIFT;
        clamp_c   = '0;
`ifdef GABOR_ABS_EN
        mag_c     = -shifted_c;
`endif
        if (shifted_c[ACC_W-1]) begin
`ifdef GABOR_ABS_EN
            clamp_c = (mag_c > ACC_W'(255)) ? DATA_W'(255) : mag_c[DATA_W-1:0];
`else
            clamp_c = '0;
`endif
        end else if (shifted_c > ACC_W'(255)) begin
            clamp_c = DATA_W'(255);
        end else begin
            clamp_c = shifted_c[DATA_W-1:0];
        end
    end

    // Capture the finished window so back-to-back windows can reuse the accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fin_data <= '0;
            fin_addr <= '0;
        end else if (s2_last) begin
            fin_data <= clamp_c;
            fin_addr <= s2_center;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_next = ACCUM;
                end
            end
            ACCUM, EMIT: begin
                if (s2_last) begin
                    state_next = EMIT;
                end else if (win_open || accept_c) begin
                    state_next = ACCUM;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: write strobe for one cycle per EMIT, busy, sticky frame_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_we_q   <= 1'b0;
            out_data_q <= '0;
            out_addr_q <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_we_q <= (state == EMIT);
            busy     <= (state_next != IDLE);
            if (state == EMIT) begin
                out_data_q <= fin_data;
                out_addr_q <= fin_addr;
                if (fin_addr == LAST_ADDR) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

    assign bus.out_we   = out_we_q;
    assign bus.out_data = out_data_q;
    assign bus.out_addr = out_addr_q;

endmodule

// File: tb/tb_gabor_mac.sv
// Directed bench for gabor_mac: two instances (SHIFT=7 and SHIFT=0) see the
// same taps; a reference model queues expected (addr, data, cycle) per window.
module tb_gabor_mac;

    logic clk;
    logic reset;
    logic busy7, busy0, fd7, fd0;

    gabor_mac_if bus7 ();
    gabor_mac_if bus0 ();

    gabor_mac #(.SHIFT(7), .IMG_PIXELS(256)) u_dut7 (
        .clk(clk), .reset(reset), .bus(bus7), .busy(busy7), .frame_done(fd7)
    );
    gabor_mac #(.SHIFT(0), .IMG_PIXELS(256)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .busy(busy0), .frame_done(fd0)
    );

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t q7[$];
    exp_t q0[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   fd_exp7 = 0;
    bit   fd_exp0 = 0;
    int   wp[9];
    int   wc[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference clamp: arithmetic shift then saturate to a pixel.
    function automatic int model_out(input int sum, input int sh);
        int s;
        s = sum >>> sh;
`ifdef GABOR_ABS_EN
        if (s < 0) s = -s;
`endif
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic drive_tap(input int idx, input int pix, input int cof, input bit last, input int center);
        @(negedge clk);
        bus7.tap_valid = 1'b1;   bus0.tap_valid = 1'b1;
        bus7.tap_idx   = 4'(idx); bus0.tap_idx  = 4'(idx);
        bus7.pixel_in  = 8'(pix); bus0.pixel_in = 8'(pix);
        bus7.coeff_in  = 8'(cof); bus0.coeff_in = 8'(cof);
        bus7.win_last  = last;   bus0.win_last  = last;
        bus7.center_in = 8'(center); bus0.center_in = 8'(center);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus7.tap_valid = 1'b0; bus0.tap_valid = 1'b0;
            bus7.win_last  = 1'b0; bus0.win_last  = 1'b0;
        end
    endtask

    // Full 9-tap window from wp/wc; optional out-of-range junk tap before tap junk_at.
    task automatic send_window(input int center, input int junk_at);
        int   sum;
        exp_t e;
        sum = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == junk_at) drive_tap(12, 255, 127, 1'b1, 99);
            drive_tap(i, wp[i], wc[i], i == 8, center);
            sum += wp[i] * wc[i];
            if (i == 8) begin
                e.addr = center;
                e.cyc  = cyc + 4;
                e.data = model_out(sum, 7);
                q7.push_back(e);
                e.data = model_out(sum, 0);
                q0.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q7.size() != 0 || q0.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_q7", q7.size(), 0);
        check("drain_q0", q0.size(), 0);
        idle(3);
    endtask

    task automatic set_const(input int p, input int c);
        for (int i = 0; i < 9; i++) begin
            wp[i] = p;
            wc[i] = c;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < 9; i++) begin
            wp[i] = int'($urandom_range(255));
            wc[i] = int'($urandom_range(255)) - 128;
        end
    endtask

    // Scoreboard: every write must match the oldest expected entry in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus7.out_we === 1'b1) begin
            check("write7_expected", q7.size() != 0, 1);
            if (q7.size() != 0) begin
                e = q7.pop_front();
                if (e.addr == 255) fd_exp7 = 1'b1;
                check("addr7", bus7.out_addr, e.addr);
                check("data7", bus7.out_data, e.data);
                check("cycle7", cyc, e.cyc);
                check("frame_done7", fd7, fd_exp7);
            end
        end
        if (bus0.out_we === 1'b1) begin
            check("write0_expected", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                if (e.addr == 255) fd_exp0 = 1'b1;
                check("addr0", bus0.out_addr, e.addr);
                check("data0", bus0.out_data, e.data);
                check("cycle0", cyc, e.cyc);
                check("frame_done0", fd0, fd_exp0);
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus7.tap_valid = 1'b0; bus0.tap_valid = 1'b0;
        bus7.tap_idx = '0;     bus0.tap_idx = '0;
        bus7.pixel_in = '0;    bus0.pixel_in = '0;
        bus7.coeff_in = '0;    bus0.coeff_in = '0;
        bus7.win_last = 1'b0;  bus0.win_last = 1'b0;
        bus7.center_in = '0;   bus0.center_in = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_out_we", bus7.out_we, 0);
        check("rst_out_data", bus7.out_data, 0);
        check("rst_out_addr", bus7.out_addr, 0);
        check("rst_busy", busy7, 0);
        check("rst_frame_done", fd7, 0);
        check("rst_out_we0", bus0.out_we, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Non-zero tap in IDLE is dropped
        drive_tap(3, 50, 50, 1'b1, 77);
        idle(8);
        check("idle_discard_busy", busy7, 0);

        // 9 x (100 * +1) = 900 -> 255 at SHIFT=0, 7 at SHIFT=7
        set_const(100, 1);
        send_window(5, -1);
        check("busy_in_window", busy7, 1);
        idle(1);
        drain();
        check("busy_after_emit", busy7, 0);

        // 9 x (255 * -128): negative sum
        set_const(255, -128);
        send_window(6, -1);
        idle(1);
        drain();

        // Single nonzero tap at index 4: 16 * 8 = 128 -> 1 at SHIFT=7
        set_const(0, 0);
        wp[4] = 16;
        wc[4] = 8;
        send_window(8, -1);
        idle(1);
        drain();

        // Back-to-back windows: center 10 -> 9, center 11 -> 0
        set_const(64, 2);
        send_window(10, -1);
        set_const(0, 0);
        send_window(11, -1);
        idle(1);
        drain();

        // Out-of-range tap index inside a window is ignored
        set_rand();
        send_window(12, 5);
        idle(1);
        drain();

        // Restart with tap 0 before win_last abandons the open window
        for (int i = 0; i < 4; i++) drive_tap(i, 200, 100, 1'b0, 30);
        set_rand();
        send_window(31, -1);
        idle(1);
        drain();

        // Reset during tap 4 of center 20 discards the window
        for (int i = 0; i < 9; i++) begin
            drive_tap(i, 90, 90, i == 8, 20);
            if (i == 4) reset = 1'b0;
            if (i == 5) check("busy_in_reset", busy7, 0);
            if (i == 6) reset = 1'b1;
        end
        fd_exp7 = 1'b0;
        fd_exp0 = 1'b0;
        idle(8);
        check("busy_after_reset", busy7, 0);
        set_rand();
        send_window(21, -1);
        idle(1);
        drain();

        // Full frame: centers 0..255 back-to-back
        check("frame_done_before", fd7, 0);
        for (int c = 0; c < 256; c++) begin
            set_rand();
            send_window(c, -1);
        end
        idle(1);
        drain();
        check("frame_done_hold7", fd7, 1);
        check("frame_done_hold0", fd0, 1);

        // Writes continue normally after frame_done
        set_rand();
        send_window(3, -1);
        idle(1);
        drain();
        check("frame_done_sticky", fd7, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gabor_mac.md
GABOR_MAC -- requirements
Module: gabor_mac

Interface
REQ-001 Parameter SHIFT, default 7, right-shift applied to the accumulated sum before output clamping.
REQ-002 Parameter IMG_PIXELS, default 256, number of output pixels per frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when low.
REQ-005 tap_valid  input  1  pixel_in/coeff_in/tap_idx valid this cycle.
REQ-006 tap_idx  input  4  kernel tap index 0..8 of the current sample.
REQ-007 pixel_in  input  8  unsigned image pixel read from image memory.
REQ-008 coeff_in  input  8  signed two's-complement Gabor coefficient from kernel ROM.
REQ-009 win_last  input  1  marks the sample as the last tap of the current window.
REQ-010 center_in  input  8  output pixel address of the current window.
REQ-011 out_data  output  8  clamped, scaled filter result.
REQ-012 out_addr  output  8  output memory write address.
REQ-013 out_we  output  1  one-cycle write strobe for out_data/out_addr.
REQ-014 busy  output  1  high while a window is being accumulated or emitted.
REQ-015 frame_done  output  1  sticky; high once pixel IMG_PIXELS-1 is written.

Function
REQ-016 Stage 1 SHALL register product = $signed({1'b0,pixel_in}) * $signed(coeff_in) as 17-bit signed, plus tap_idx, win_last and center_in, when tap_valid=1.
REQ-017 Stage 2 SHALL hold a 21-bit signed accumulator; a stage-1 sample with tap_idx=0 loads acc=product, otherwise acc=acc+product.
REQ-018 Samples with tap_idx>8 SHALL be discarded at stage 1 (no accumulate, no emit).
REQ-019 When the stage-2 sample has win_last=1, the next cycle SHALL assert out_we=1 for exactly one cycle with out_addr=registered center_in.
REQ-020 Latency: out_we SHALL rise exactly 3 clk edges after the edge sampling the win_last tap.
REQ-021 out_data SHALL be the final sum arithmetically shifted right by SHIFT, then clamped: <0 -> 0, >255 -> 255, else the low 8 bits.
REQ-022 State machine: IDLE (no window) -> ACCUM on accepted tap_idx=0 -> EMIT on win_last in stage 2 -> ACCUM if a tap_idx=0 is in flight, else IDLE.
REQ-023 busy SHALL be 1 in ACCUM and EMIT, 0 in IDLE.
REQ-024 Back-to-back windows (tap_idx=0 on the cycle after win_last) SHALL be accepted with no stall and no corruption of either result.
REQ-025 A tap_idx=0 arriving before win_last SHALL abandon the open window without any write and start a new one.
REQ-026 A non-zero tap_idx arriving in IDLE SHALL be discarded.
REQ-027 frame_done SHALL set on the cycle out_we writes out_addr=IMG_PIXELS-1 and hold until reset.
REQ-028 Writes after frame_done SHALL still be performed normally.

Reset
REQ-029 While reset=0: out_data=0, out_addr=0, out_we=0, busy=0, frame_done=0, accumulator=0, pipeline valid flags=0, state=IDLE.
REQ-030 Reset asserted mid-window SHALL discard the partial sum; no out_we after release until a complete new window.

Configuration
REQ-031 Macro GABOR_ABS_EN: when defined, negative shifted sums SHALL output min(|sum|,255); when undefined, negatives clamp to 0 per REQ-021.

Verification
REQ-032 Nine taps pixel=100, coeff=+1, center_in=5, SHIFT=0 -> single out_we with out_addr=5, out_data=255 (900 clamped).
REQ-033 Nine taps pixel=255, coeff=-128, SHIFT=7 -> out_data=0; with GABOR_ABS_EN -> 255.
REQ-034 Taps pixel=16, coeff=+8 (one tap only nonzero, tap_idx=4), SHIFT=7 -> out_data=1; out_we exactly 3 edges after win_last.
REQ-035 Two windows back-to-back, center 10 (all +2 x 64, SHIFT=7 -> 9) and 11 (all 0) -> writes (10,9) then (11,0) on consecutive-window cadence.
REQ-036 reset=0 pulse during tap 4 of center 20 -> no write for address 20; next full window center 21 writes correctly.
REQ-037 256 windows with center 0..255 -> 256 out_we pulses, frame_done=1 on the cycle writing address 255, still 1 afterwards.
